// File: rtl/serializer_pkg.sv
// serializer_pkg: shared sizing and packing helpers for the serializer.
// The eot flag sits EOT_GAP bits above the top bit of each chunk.
package serializer_pkg;

  localparam int EOT_GAP = 0;

  typedef enum logic {
    EOT_MID  = 1'b0,
    EOT_LAST = 1'b1
  } eot_e;

  function automatic int cnt_width(input int num);
    int w;
    w = $clog2(num);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dti.sv
// dti: valid/ready stream handshake bundle.
// A transfer happens on a clock edge where valid and ready are both high.
interface dti #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (
    output valid,
    output data,
    input  ready
  );

  modport consumer (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/serializer.sv
// serializer: splits one DIN-bit word into NUM chunks with eot on the last.
// Define SERIALIZER_MSB_FIRST_EN to emit the most significant chunk first.
module serializer
  import serializer_pkg::*;
#(
  parameter int DIN = 16,
  parameter int NUM = 4
) (
  input logic  clk,
  input logic  rst,
  dti.consumer din,
  dti.producer dout
);

  localparam int W       = DIN / NUM;
  localparam int CW      = cnt_width(NUM);
  localparam int EOT_BIT = W + EOT_GAP;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM - 1);

  if (NUM < 2 || (DIN % NUM) != 0) begin : g_bad_cfg
    $error("serializer: need NUM >= 2 and DIN divisible by NUM");
  end

  logic [DIN-1:0] r_hold;
  logic           r_busy;
  logic [CW-1:0]  r_cnt;

  logic [NUM-1:0][W-1:0] w_chunks;
  logic [CW-1:0]         w_idx;
  logic [W-1:0]          w_chunk;
  logic                  w_last;
  logic                  w_in_hs;
  logic                  w_out_hs;
  eot_e                  w_eot;

  assign w_last   = r_busy && (r_cnt == LAST_CNT);
  assign w_out_hs = r_busy && dout.ready;
  assign w_in_hs  = din.valid && din.ready;

`ifdef SERIALIZER_MSB_FIRST_EN
  assign w_idx = LAST_CNT - r_cnt;
`else
  assign w_idx = r_cnt;
`endif

  assign w_chunks = r_hold;
  assign w_chunk  = w_chunks[w_idx];
  assign w_eot    = w_last ? EOT_LAST : EOT_MID;

  // a new word may land while the last chunk of the old one leaves
  assign din.ready  = !r_busy || (w_last && dout.ready);
  assign dout.valid = r_busy;

  assign dout.data[EOT_BIT]   = w_eot;
  assign dout.data[W-1:0]     = w_chunk;

  // word capture, chunk counter and drain of the held word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else if (w_in_hs) begin
      r_hold <= din.data;
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (w_out_hs && w_last) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_out_hs) begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Downstream neighbour of the stream decoupler. Consumes one wide word per dti handshake and emits it as NUM narrow chunks on a dti producer.
- Each output chunk carries an end-of-transfer flag that is set on the last chunk.
- Used where a buffered wide stream feeds a narrow datapath, e.g. a 16-bit word into a 4-bit lane.
- Holds one word internally, so throughput is one chunk per cycle, including back-to-back words.

Parameters:
- DIN, 16, total input data width; must equal NUM*W.
- NUM, 4, chunks per word; NUM >= 2; need not be a power of two.
- W, DIN/NUM, chunk width; localparam, not overridable.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- din  dti.consumer  DIN  wide input word; din.valid/din.ready handshake.
- dout  dti.producer  W+1  dout.data = {eot, chunk}; eot is bit W; chunk is bits W-1:0.

Behaviour:
- Elaboration checks:
  - DIN % NUM != 0 or NUM < 2 -> $error at elaboration.
  - Counter cnt has width max(1, $clog2(NUM)).
- State:
  - hold_data[DIN-1:0].
  - busy (1 bit).
  - cnt counting 0..NUM-1.
- Reset (sync, rst high at posedge): busy=0, cnt=0, hold_data=0.
  - Outputs after reset: dout.valid=0, dout.data=0, din.ready=1.
- Definitions:
  - last = busy & (cnt == NUM-1).
  - out_hs = dout.valid & dout.ready.
  - in_hs = din.valid & din.ready.
- din.ready = ~busy | (last & dout.ready).
  - Combinational from dout.ready.
  - No combinational path from din.valid to din.ready.
- dout.valid = busy.
- Chunk select: dout.data[W-1:0] = hold_data[cnt*W +: W].
- dout.data[W] = last.
- Transitions per cycle:
  - in_hs: hold_data <= din.data, busy <= 1, cnt <= 0. This covers both the idle case and the simultaneous last-chunk-out/new-word-in case.
  - else out_hs & last: busy <= 0, cnt <= 0.
  - else out_hs: cnt <= cnt + 1.
  - else: hold.
- Latency: first chunk is valid the cycle after the din handshake. Back-to-back words produce no bubble: NUM chunks every NUM cycles under constant dout.ready.
- Backpressure: dout.ready=0 freezes cnt and hold_data. dout.data and dout.valid must stay stable while valid & ~ready (dti rule).
- Wrap: cnt never exceeds NUM-1. For non-power-of-two NUM, counter values >= NUM are unreachable.
- Reset mid-word: the remaining chunks are discarded and no partial eot is emitted.
- Reset dominates a simultaneous din handshake: a word presented with rst high is dropped.

Optional Feature:
- SERIALIZER_MSB_FIRST_EN.
- Defined: chunk order is reversed; chunk index is NUM-1-cnt, so the most significant chunk goes first. The eot flag is still tied to cnt == NUM-1.
- Undefined (default): LSB-first as above.
- Handshake and timing are identical in both modes.

Decomposition:
- Package serializer_pkg holds:
  - the function cnt_width(NUM) returning max(1, $clog2(NUM));
  - the localparam EOT_BIT convention (bit W of output);
  - a typedef helper for the {eot, chunk} packing.
- No sub-module needed. Counter and chunk mux stay in a single always_ff plus a single assign block.

Test Plan:
- Basic: DIN=16, NUM=4, din=0xA5C3, dout.ready=1 -> dout.data sequence 0x3, 0xC, 0x5, 0x1A (eot=1 on last) over 4 consecutive cycles; din.ready low for cycles 2-4, high on last.
- Back-to-back: 0x1234 then 0xBEEF, din.valid constant, dout.ready=1 -> 8 consecutive chunks 4,3,2,1,F,E,E,B with no bubble; eot on chunks 4 and 8.
- Backpressure: 0xA5C3 with dout.ready toggling 1,0,0,1,1,0,1 -> chunks stable while stalled; exactly 4 outputs; data 3,C,5,A; no duplicates or drops.
- Non-power-of-two: DIN=12, NUM=3, din=0xABC -> C, B, A (eot on A); next word 0x123 -> 3, 2, 1; cnt never reaches 3.
- Reset mid-word: rst pulsed after 2nd chunk of 0xA5C3 -> dout.valid=0 the next cycle, din.ready=1; next word 0x0F0F yields F,0,F,0 from chunk 0.
- Macro SERIALIZER_MSB_FIRST_EN defined: din=0xA5C3 -> A, 5, C, 3 with eot on 3; same cycle timing as the basic case.
